// File: rtl/rf_multiport_if.sv
// Register-file access bus: decode-stage read ports, writeback-stage write ports, and ready.
// The control/datapath side uses master; the register file uses slave.
interface rf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic              ready;

    modport master (
        output ra1, ra2, we0, wa0, wd0, we1, wa1, wd1,
        input  rd1, rd2, ready
    );

    modport slave (
        input  ra1, ra2, we0, wa0, wd0, we1, wa1, wd1,
        output rd1, rd2, ready
    );
endinterface

// File: rtl/rf_multiport.sv
// 2-read / 2-write register file with write-port priority, optional write-to-read bypass,
// optional hardwired zero register, and a one-entry-per-cycle clear sweep after reset.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    rf_multiport_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic              r_ready;
    logic [DATA_W-1:0] r_rf [DEPTH];

    logic              w_in_ready;
    logic              w_wr0;
    logic              w_wr1;
    logic [DATA_W-1:0] w_rf1;
    logic [DATA_W-1:0] w_rf2;

    assign w_in_ready = (r_state == S_READY);

    // Port 0 is suppressed on an address clash so the array never sees two writes to one entry.
    assign w_wr1 = w_in_ready && bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));
    assign w_wr0 = w_in_ready && bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0))
                   && !(bus.we1 && (bus.wa1 == bus.wa0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == LAST_IDX) begin
                r_state <= S_READY;
                r_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                r_rf[r_clr_idx] <= '0;
            end else begin
                if (w_wr0) r_rf[bus.wa0] <= bus.wd0;
                if (w_wr1) r_rf[bus.wa1] <= bus.wd1;
            end
        end
    end

    assign w_rf1 = r_rf[bus.ra1];
    assign w_rf2 = r_rf[bus.ra2];

    function automatic logic [DATA_W-1:0] f_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] v;
        if (!w_in_ready)
            v = '0;
        else if ((ZERO_REG != 0) && (addr == '0))
            v = '0;
        else if ((BYPASS != 0) && bus.we1 && (bus.wa1 == addr))
            v = bus.wd1;
        else if ((BYPASS != 0) && bus.we0 && (bus.wa0 == addr))
            v = bus.wd0;
        else
            v = stored;
        return v;
    endfunction

    always_comb begin
        bus.rd1 = f_read(bus.ra1, w_rf1);
        bus.rd2 = f_read(bus.ra2, w_rf2);
    end

    assign bus.ready = r_ready;
endmodule
